nano_io_port: RTL
=================

Name: nano_io_port

Overview:
- Peripheral end of the Nano core's OUTPUT/INPUT instructions.
- Output side: accepts the controller's one-cycle LdOUTPUT strobe with a data byte and buffers it in a small FIFO. Drains the FIFO to an external consumer over a valid/ready handshake.
- Input side: receives bytes from an external producer over valid/ready into a one-entry holding register. The core consumes that register with a read strobe.
- The controller never stalls, so loss is flagged rather than back-pressured.

Parameters:
- DATA_W, 8, width of data bytes.
- DEPTH_LOG2, 2, log2 of output FIFO depth (default 4 entries); legal 1..4.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- LdOUTPUT, input, 1, one-cycle write strobe from controller.
- DtOUT, input, DATA_W, byte to output; sampled when LdOUTPUT=1.
- out_data, output, DATA_W, FIFO head byte.
- out_valid, output, 1, FIFO non-empty.
- out_ready, input, 1, external consumer accepts out_data.
- Full, output, 1, FIFO holds DEPTH entries.
- Overflow, output, 1, sticky: a write was dropped.
- OutCount, output, DEPTH_LOG2+1, FIFO occupancy.
- in_data, input, DATA_W, external input byte.
- in_valid, input, 1, external producer offers in_data.
- in_ready, output, 1, holding register free.
- RdINPUT, input, 1, core consumes held input byte.
- DtIN, output, DATA_W, held input byte.
- InAvail, output, 1, holding register full.

Behaviour:
- Reset (rst=1 at clock edge):
  - Read/write pointers cleared; OutCount=0, out_valid=0, Full=0, Overflow=0.
  - InAvail=0, DtIN=0.
  - in_ready is 0 while rst=1 and 1 on the first cycle after rst falls.
  - Reset mid-transfer discards all FIFO contents and any held input byte. No partial state survives.
- Output FIFO:
  - Storage is DEPTH x DATA_W; pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
  - OutCount is 0..DEPTH.
  - out_data = mem[rd_ptr], combinational from the array. It is defined only when out_valid=1.
  - out_valid = (OutCount!=0); Full = (OutCount==DEPTH); all registered-derived.
  - pop = out_valid & out_ready.
  - push = LdOUTPUT & (~Full | pop).
- Latency:
  - Push at edge N makes the byte visible on out_data, with out_valid=1, from edge N onward (cycle N+1) if the FIFO was empty.
  - No pass-through of DtOUT to out_data in the same cycle.
- Push and pop:
  - Empty FIFO with LdOUTPUT=1: push only, since pop cannot occur; OutCount becomes 1.
  - Full FIFO with pop and LdOUTPUT in the same cycle: both happen. OutCount stays DEPTH and the new byte is written into the freed slot.
  - Non-empty, non-full FIFO with push and pop together: OutCount unchanged.
- Overflow:
  - LdOUTPUT=1 & Full=1 & pop=0 drops DtOUT and sets Overflow=1.
  - Overflow stays 1 until rst.
  - Contents and OutCount are unchanged by a dropped write.
- out_ready while out_valid=0 has no effect.
- Output order is strict FIFO.
- Input holding register:
  - in_ready = ~InAvail (0 during reset).
  - Capture: in_valid & in_ready loads DtIN<=in_data and sets InAvail<=1.
  - Consume: RdINPUT & InAvail clears InAvail at the edge.
  - DtIN holds its value until the next capture.
  - Because in_ready=0 while InAvail=1, capture and consume never coincide. After a consume, in_ready rises the next cycle, giving one free cycle minimum between bytes.
  - RdINPUT while InAvail=0 is ignored.
  - in_valid while in_ready=0: producer must hold in_data stable and in_valid high. The block takes no action.
- Output side and input side are fully independent; simultaneous activity on both is legal.

Test Plan:
- Reset check: assert rst 2 cycles with LdOUTPUT=1, DtOUT=8'hAA, in_valid=1 -> after reset out_valid=0, OutCount=0, Overflow=0, InAvail=0, DtIN=8'h00, in_ready=1.
- Order and wrap: out_ready=0; pulse LdOUTPUT with 8'h11, 8'h22, 8'h33, 8'h44 -> Full=1, OutCount=4. Raise out_ready -> out_data 11,22,33,44 on consecutive cycles, then out_valid=0. Repeat 6 bytes streaming with out_ready=1 to exercise pointer wrap -> order preserved.
- Overflow: fill 4 entries, out_ready=0, LdOUTPUT with 8'h55 -> Overflow=1, OutCount=4, drained sequence excludes 55. Overflow remains 1 after the FIFO empties.
- Full with simultaneous push and pop: FIFO full, out_ready=1 and LdOUTPUT with 8'h66 in the same cycle -> OutCount stays 4, Overflow=0, 66 emerges last.
- Input handshake: in_valid=1, in_data=8'h9C -> next cycle InAvail=1, DtIN=9C, in_ready=0. Change in_data to 8'h3D while held -> DtIN stays 9C. RdINPUT=1 -> InAvail=0, and the following cycle in_ready=1 captures 3D. RdINPUT with InAvail=0 -> no change.
- Reset mid-operation: 3 bytes queued and InAvail=1, pulse rst -> all FIFO contents lost, OutCount=0, InAvail=0. A subsequent push of 8'h77 appears as first out_data.

Source files
------------

// File: rtl/nano_io_port.sv
// rtl/nano_io_port.sv - Nano core OUTPUT/INPUT peripheral: output byte FIFO plus one-entry input holding register
module nano_io_port #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  // controller OUTPUT instruction side
  input  logic                  LdOUTPUT,
  input  logic [DATA_W-1:0]     DtOUT,
  // external consumer of output bytes
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  // output FIFO status
  output logic                  Full,
  output logic                  Overflow,
  output logic [DEPTH_LOG2:0]   OutCount,
  // external producer of input bytes
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  // controller INPUT instruction side
  input  logic                  RdINPUT,
  output logic [DATA_W-1:0]     DtIN,
  output logic                  InAvail
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow_q;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // Status is derived from the registered occupancy only, so the head byte is
  // never a same-cycle pass-through of DtOUT.
  assign out_valid = (count != '0);
  assign Full      = (count == DEPTH_CNT);
  assign OutCount  = count;
  assign Overflow  = overflow_q;
  assign out_data  = mem[rd_ptr];

  // A full FIFO can still accept a byte in the cycle its head is consumed,
  // because the freed slot is the one the write pointer lands on.
  assign pop  = out_valid & out_ready;
  assign push = LdOUTPUT & (~Full | pop);
  assign drop = LdOUTPUT & Full & ~pop;

  // Storage write; contents need no reset since out_data is qualified by out_valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= DtOUT;
    end
  end

  // Pointer advance; both wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Occupancy tracking; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky loss flag: the controller cannot stall, so a dropped byte is only
  // reported, and the report survives until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Input holding register
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] dtin_q;
  logic              avail_q;
  logic              capture;
  logic              consume;

  // Free slot advertised only outside reset; held low while a byte waits, so
  // capture and consume can never land on the same edge.
  assign in_ready = ~rst & ~avail_q;
  assign capture  = in_valid & in_ready;
  assign consume  = RdINPUT & avail_q;
  assign DtIN     = dtin_q;
  assign InAvail  = avail_q;

  // Capture from the producer or release to the core; data persists until
  // the next capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      dtin_q  <= '0;
      avail_q <= 1'b0;
    end else if (capture) begin
      dtin_q  <= in_data;
      avail_q <= 1'b1;
    end else if (consume) begin
      avail_q <= 1'b0;
    end
  end

endmodule
